// File: rtl/reset_sequencer_if.sv
// Interface bundling the soft-reset handshake and the domain reset outputs of
// the reset sequencer. The sequencer uses the slave side; requesters and the
// consumers of the domain resets use the master side.
interface reset_sequencer_if #(
  parameter int STAGES = 3,
  parameter int NREQ   = 2
);

  logic [NREQ-1:0]   sreq_i;
  logic [NREQ-1:0]   sack_o;
  logic [STAGES-1:0] nreset_o;
  logic              ready_o;

  modport master (
    output sreq_i,
    input  sack_o,
    input  nreset_o,
    input  ready_o
  );

  modport slave (
    input  sreq_i,
    output sack_o,
    output nreset_o,
    output ready_o
  );

endinterface

// File: rtl/reset_sequencer.sv
// Staged reset controller. Holds every domain in reset for a while after the
// board reset, then releases the domains one at a time, lowest index first.
// Soft-reset requests seen while idle are merged into one shared re-sequence
// and acknowledged together once all domains are released again.
module reset_sequencer #(
  parameter int STAGES      = 3,
  parameter int HOLD_CYCLES = 32,
  parameter int STAGE_GAP   = 16,
  parameter int NREQ        = 2
) (
  input  logic               clk_i,
  input  logic               reset_i,
  reset_sequencer_if.slave   bus
);

  localparam int MAX_CYCLES = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
  localparam int CW         = $clog2(MAX_CYCLES) + 1;
  localparam int SW         = (STAGES > 1) ? $clog2(STAGES) : 1;

  localparam logic [CW-1:0]     HOLD_LOAD = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0]     GAP_LOAD  = CW'(STAGE_GAP - 1);
  localparam logic [SW-1:0]     LAST_STG  = SW'(STAGES - 1);
  localparam logic [STAGES-1:0] FIRST_STG = STAGES'(1);

  typedef enum logic [1:0] {
    ST_HOLD,
    ST_RELEASE,
    ST_DONE,
    ST_RUN
  } state_t;

  logic [1:0]        sync_q, sync_d;
  logic              rst_s;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [SW-1:0]     stg_q, stg_d;
  logic [NREQ-1:0]   cap_q, cap_d;
  logic [STAGES-1:0] nreset_q, nreset_d;
  logic              ready_q, ready_d;
  logic [NREQ-1:0]   sack_q, sack_d;
  logic              fresh_q, fresh_d;

  // Two-flop synchronizer: assertion of reset_i is immediate, release is
  // retimed so the FSM only starts on a clean clock boundary.
  always_comb begin
    sync_d = {sync_q[0], 1'b1};
  end

  // Synchronizer register, cleared asynchronously by the board reset.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign rst_s = sync_q[1];

  // Next-state logic; nothing advances until the synchronized reset is high.
  // fresh marks the first RUN cycle after DONE, in which requesters are still
  // seeing their ack and have not yet dropped their request.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    stg_d    = stg_q;
    cap_d    = cap_q;
    nreset_d = nreset_q;
    ready_d  = ready_q;
    sack_d   = '0;
    fresh_d  = 1'b0;

    if (rst_s) begin
      unique case (state_q)
        ST_HOLD: begin
          nreset_d = '0;
          ready_d  = 1'b0;
          if (cnt_q == '0) begin
            nreset_d = FIRST_STG;
            cnt_d    = GAP_LOAD;
            stg_d    = SW'(1);
            state_d  = (STAGES == 1) ? ST_DONE : ST_RELEASE;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end

        ST_RELEASE: begin
          if (cnt_q == '0) begin
            nreset_d = nreset_q | (FIRST_STG << stg_q);
            if (stg_q == LAST_STG) begin
              state_d = ST_DONE;
            end else begin
              stg_d = stg_q + SW'(1);
              cnt_d = GAP_LOAD;
            end
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end

        ST_DONE: begin
          ready_d = 1'b1;
          sack_d  = cap_q;
          cap_d   = '0;
          fresh_d = 1'b1;
          state_d = ST_RUN;
        end

        ST_RUN: begin
          ready_d = 1'b1;
          if (!fresh_q && (|bus.sreq_i)) begin
            cap_d    = bus.sreq_i;
            nreset_d = '0;
            ready_d  = 1'b0;
            cnt_d    = HOLD_LOAD;
            state_d  = ST_HOLD;
          end
        end
      endcase
    end
  end

  // State and output registers; the board reset drops every output at once.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q  <= ST_HOLD;
      cnt_q    <= HOLD_LOAD;
      stg_q    <= '0;
      cap_q    <= '0;
      nreset_q <= '0;
      ready_q  <= 1'b0;
      sack_q   <= '0;
      fresh_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      stg_q    <= stg_d;
      cap_q    <= cap_d;
      nreset_q <= nreset_d;
      ready_q  <= ready_d;
      sack_q   <= sack_d;
      fresh_q  <= fresh_d;
    end
  end

  assign bus.nreset_o = nreset_q;
  assign bus.ready_o  = ready_q;
  assign bus.sack_o   = sack_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: a main instance with HOLD_CYCLES=4,
// STAGE_GAP=2, STAGES=3, NREQ=2 and a degenerate instance with STAGES=1,
// HOLD_CYCLES=1 sharing the same clock and board reset.
module tb_reset_sequencer;

  logic clk_i;
  logic reset_i;

  int n_checks;
  int n_fail;

  reset_sequencer_if #(.STAGES(3), .NREQ(2)) bus_main ();
  reset_sequencer_if #(.STAGES(1), .NREQ(1)) bus_deg ();

  reset_sequencer #(
    .STAGES      (3),
    .HOLD_CYCLES (4),
    .STAGE_GAP   (2),
    .NREQ        (2)
  ) dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .bus     (bus_main)
  );

  reset_sequencer #(
    .STAGES      (1),
    .HOLD_CYCLES (1),
    .STAGE_GAP   (2),
    .NREQ        (1)
  ) dut_deg (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .bus     (bus_deg)
  );

  // Free-running 10-unit clock.
  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Expected main-instance domain resets k edges after the sequence start
  // (HOLD=4, GAP=2): bit k rises after 4+2k edges.
  function automatic logic [2:0] exp_nreset(input int k);
    if (k >= 8) return 3'b111;
    if (k >= 6) return 3'b011;
    if (k >= 4) return 3'b001;
    return 3'b000;
  endfunction

  // Advance n rising edges and settle just after the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    #3;
    n_checks++;
    if (bus_main.nreset_o !== 3'b000) begin
      n_fail++;
      $display("[TB] FAIL reset_nreset: got %b expected 000", bus_main.nreset_o);
    end
    n_checks++;
    if (bus_main.ready_o !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_ready: got %b expected 0", bus_main.ready_o);
    end
    n_checks++;
    if (bus_main.sack_o !== 2'b00) begin
      n_fail++;
      $display("[TB] FAIL reset_sack: got %b expected 00", bus_main.sack_o);
    end
    step(3);
    n_checks++;
    if (bus_main.nreset_o !== 3'b000 || bus_deg.nreset_o !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_held: got %b/%b expected 000/0",
               bus_main.nreset_o, bus_deg.nreset_o);
    end
  endtask

  // Releases the board reset before edge 1 and follows the power-up schedule
  // of both instances through edge 12.
  task automatic test_power_up(input string tag);
    @(negedge clk_i);
    reset_i = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      step(1);
      n_checks++;
      if (bus_main.nreset_o !== exp_nreset(e - 2)) begin
        n_fail++;
        $display("[TB] FAIL %s_nreset_e%0d: got %b expected %b",
                 tag, e, bus_main.nreset_o, exp_nreset(e - 2));
      end
      n_checks++;
      if (bus_main.ready_o !== (e >= 11)) begin
        n_fail++;
        $display("[TB] FAIL %s_ready_e%0d: got %b expected %b",
                 tag, e, bus_main.ready_o, (e >= 11));
      end
      n_checks++;
      if (bus_main.sack_o !== 2'b00) begin
        n_fail++;
        $display("[TB] FAIL %s_sack_e%0d: got %b expected 00", tag, e, bus_main.sack_o);
      end
      n_checks++;
      if (bus_deg.nreset_o !== (e >= 3) || bus_deg.ready_o !== (e >= 4)) begin
        n_fail++;
        $display("[TB] FAIL %s_deg_e%0d: got nreset=%b ready=%b expected nreset=%b ready=%b",
                 tag, e, bus_deg.nreset_o, bus_deg.ready_o, (e >= 3), (e >= 4));
      end
    end
  endtask

  // One soft sequence from RUN; the request is held through the first RUN
  // cycle after the ack to confirm it is not re-captured there.
  task automatic test_soft_request(input logic [1:0] mask, input string tag);
    logic [1:0] exp_sack;
    bus_main.sreq_i = mask;
    for (int k = 0; k <= 11; k++) begin
      step(1);
      exp_sack = (k == 9) ? mask : 2'b00;
      n_checks++;
      if (bus_main.nreset_o !== exp_nreset(k)) begin
        n_fail++;
        $display("[TB] FAIL %s_nreset_S+%0d: got %b expected %b",
                 tag, k, bus_main.nreset_o, exp_nreset(k));
      end
      n_checks++;
      if (bus_main.ready_o !== (k >= 9)) begin
        n_fail++;
        $display("[TB] FAIL %s_ready_S+%0d: got %b expected %b",
                 tag, k, bus_main.ready_o, (k >= 9));
      end
      n_checks++;
      if (bus_main.sack_o !== exp_sack) begin
        n_fail++;
        $display("[TB] FAIL %s_sack_S+%0d: got %b expected %b",
                 tag, k, bus_main.sack_o, exp_sack);
      end
      if (k == 10) bus_main.sreq_i = 2'b00;
    end
    step(2);
  endtask

  task automatic test_single_request();
    test_soft_request(2'b01, "single");
  endtask

  task automatic test_simultaneous();
    test_soft_request(2'b11, "simul");
  endtask

  // Requester 1 rises mid-sequence, is left pending, and is serviced by a
  // second sequence starting at S+11.
  task automatic test_request_during_sequence();
    logic [2:0] want_nreset;
    logic [1:0] want_sack;
    logic       want_ready;
    bus_main.sreq_i = 2'b01;
    for (int k = 0; k <= 22; k++) begin
      step(1);
      want_nreset = (k <= 10) ? exp_nreset(k) : exp_nreset(k - 11);
      want_ready  = (k == 9) || (k == 10) || (k >= 20);
      want_sack   = (k == 9) ? 2'b01 : ((k == 20) ? 2'b10 : 2'b00);
      n_checks++;
      if (bus_main.nreset_o !== want_nreset) begin
        n_fail++;
        $display("[TB] FAIL pend_nreset_S+%0d: got %b expected %b",
                 k, bus_main.nreset_o, want_nreset);
      end
      n_checks++;
      if (bus_main.ready_o !== want_ready) begin
        n_fail++;
        $display("[TB] FAIL pend_ready_S+%0d: got %b expected %b",
                 k, bus_main.ready_o, want_ready);
      end
      n_checks++;
      if (bus_main.sack_o !== want_sack) begin
        n_fail++;
        $display("[TB] FAIL pend_sack_S+%0d: got %b expected %b",
                 k, bus_main.sack_o, want_sack);
      end
      if (k == 3)  bus_main.sreq_i[1] = 1'b1;
      if (k == 10) bus_main.sreq_i[0] = 1'b0;
      if (k == 21) bus_main.sreq_i[1] = 1'b0;
    end
    step(2);
  endtask

  // Soft sequence on the STAGES=1, HOLD_CYCLES=1 instance.
  task automatic test_degenerate();
    bus_deg.sreq_i = 1'b1;
    for (int k = 0; k <= 4; k++) begin
      step(1);
      n_checks++;
      if (bus_deg.nreset_o !== (k >= 1)) begin
        n_fail++;
        $display("[TB] FAIL deg_nreset_S+%0d: got %b expected %b", k, bus_deg.nreset_o, (k >= 1));
      end
      n_checks++;
      if (bus_deg.ready_o !== (k >= 2)) begin
        n_fail++;
        $display("[TB] FAIL deg_ready_S+%0d: got %b expected %b", k, bus_deg.ready_o, (k >= 2));
      end
      n_checks++;
      if (bus_deg.sack_o !== (k == 2)) begin
        n_fail++;
        $display("[TB] FAIL deg_sack_S+%0d: got %b expected %b", k, bus_deg.sack_o, (k == 2));
      end
      if (k == 3) bus_deg.sreq_i = 1'b0;
    end
    step(2);
  endtask

  // Board reset in the middle of a soft sequence: outputs clear without a
  // clock edge and the aborted request is never acknowledged.
  task automatic test_reset_mid_sequence();
    bus_main.sreq_i = 2'b01;
    step(6);
    n_checks++;
    if (bus_main.nreset_o !== 3'b001) begin
      n_fail++;
      $display("[TB] FAIL abort_pre_nreset: got %b expected 001", bus_main.nreset_o);
    end
    #1;
    reset_i = 1'b0;
    bus_main.sreq_i = 2'b00;
    #1;
    n_checks++;
    if (bus_main.nreset_o !== 3'b000) begin
      n_fail++;
      $display("[TB] FAIL abort_nreset: got %b expected 000", bus_main.nreset_o);
    end
    n_checks++;
    if (bus_main.ready_o !== 1'b0 || bus_main.sack_o !== 2'b00) begin
      n_fail++;
      $display("[TB] FAIL abort_ready_sack: got ready=%b sack=%b expected 0/00",
               bus_main.ready_o, bus_main.sack_o);
    end
    n_checks++;
    if (bus_deg.nreset_o !== 1'b0 || bus_deg.ready_o !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL abort_deg: got nreset=%b ready=%b expected 0/0",
               bus_deg.nreset_o, bus_deg.ready_o);
    end
    step(2);
    test_power_up("after_abort");
  endtask

  initial begin
    n_checks        = 0;
    n_fail          = 0;
    reset_i         = 1'b0;
    bus_main.sreq_i = 2'b00;
    bus_deg.sreq_i  = 1'b0;

    test_reset();
    test_power_up("power_up");
    step(2);
    test_single_request();
    test_simultaneous();
    test_request_during_sequence();
    test_degenerate();
    test_reset_mid_sequence();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Staged reset controller for the Virtual JTAG UART design. It turns the board reset into an ordered release of `STAGES` active-low reset domains, for example the JTAG bridge first, then the FIFOs, then the user logic. It also arbitrates soft-reset requests from `NREQ` requesters, such as a host command decoder or a watchdog, into a single shared re-sequence of those domains. It sits at top level and feeds every block's reset input.

## Interface
Parameters:
- `STAGES`, 3: number of reset domains released in order, at least 1.
- `HOLD_CYCLES`, 32: cycles all domains are held in reset before the first release, at least 1.
- `STAGE_GAP`, 16: cycles between consecutive stage releases, at least 1.
- `NREQ`, 2: number of soft-reset requesters, at least 1.

Ports:
- `clk_i` input 1: single system clock.
- `reset_i` input 1: asynchronous, active-low reset. Assertion is asynchronous; deassertion is synchronized internally.
- `sreq_i` input `NREQ`: soft-reset request, one bit per requester. Level signal, held high until acknowledged.
- `sack_o` output `NREQ`: one-cycle acknowledge pulse per requester whose request was serviced.
- `nreset_o` output `STAGES`: active-low domain resets. Bit 0 is released first.
- `ready_o` output 1: high when all domains are released and the block is idle.

## Operation
- Internal 2-FF synchronizer on `reset_i`:
  - Asynchronous clear on `reset_i` low.
  - Shifts in 1 while `reset_i` is high.
  - Its output `rst_s` gates the FSM.
- The FSM, one down-counter `cnt`, one stage index `stg`, and one request mask `cap` are all asynchronously cleared by `reset_i`.
- `cnt` width is `$clog2(max(HOLD_CYCLES,STAGE_GAP))+1`. `cnt` decrements toward 0 and never wraps.
- States:
  - HOLD:
    - All `nreset_o` are 0 and `ready_o` is 0.
    - `cnt` loads `HOLD_CYCLES-1` on entry and decrements once per cycle while `rst_s` is 1.
    - At `cnt==0`, set `nreset_o[0]=1`, load `cnt=STAGE_GAP-1`, set `stg=1`, and go to RELEASE. If `STAGES==1`, go to DONE instead.
  - RELEASE:
    - `cnt` decrements each cycle.
    - At `cnt==0`, set `nreset_o[stg]=1`.
    - If `stg==STAGES-1`, go to DONE. Otherwise increment `stg` and reload `cnt=STAGE_GAP-1`.
    - Released bits stay high.
  - DONE: one cycle. `ready_o` goes to 1, `sack_o` is set to `cap`, `cap` is cleared, then go to RUN.
  - RUN:
    - `ready_o` stays 1 and `sack_o` is 0.
    - If any `sreq_i` bit is 1:
      - Set `cap` to `sreq_i`.
      - Set all `nreset_o` to 0 and `ready_o` to 0.
      - Load `cnt=HOLD_CYCLES-1` and go to HOLD.
- Arbitration:
  - Simultaneous requests are merged into one sequence, and every captured requester is acked together.
  - Requests that rise during HOLD, RELEASE or DONE are not captured. They stay pending and start a new sequence from RUN.
- Requester rule: drop `sreq_i` in the cycle after `sack_o`.
  - The block ignores `sreq_i` in the first RUN cycle after DONE.
  - A request still high in the second RUN cycle starts a new sequence.
- Reset mid-operation: `reset_i` low in any state gives the following:
  - All `nreset_o`, `ready_o`, `sack_o`, `cap` and `stg` go to 0 immediately, without waiting for a clock edge.
  - The FSM returns to HOLD.
  - No ack is issued for aborted requests.

## Timing
- Reset values: `nreset_o=0`, `ready_o=0`, `sack_o=0`, state HOLD.
- Let edge 1 be the first `clk_i` rising edge with `reset_i` high. `rst_s` rises after edge 2. The following outputs then rise after these edges:
  - `nreset_o[k]`: edge `2+HOLD_CYCLES+k*STAGE_GAP`.
  - `ready_o`, and `sack_o` for a soft sequence: edge `2+HOLD_CYCLES+(STAGES-1)*STAGE_GAP+1`.
- Soft sequence timing is measured from edge S, the edge at which RUN samples `sreq_i`:
  - All resets go low after S.
  - `nreset_o[k]` rises after `S+HOLD_CYCLES+k*STAGE_GAP`.
  - `ready_o` and `sack_o` rise after `S+HOLD_CYCLES+(STAGES-1)*STAGE_GAP+1`. `sack_o` lasts exactly 1 cycle.
- `sreq_i` is synchronous to `clk_i` and is not synchronized internally.

## Test plan
Unless stated otherwise, the bench uses `HOLD_CYCLES=4`, `STAGE_GAP=2`, `STAGES=3`, `NREQ=2`.
- **Power-up:** release `reset_i` before edge 1 → `nreset_o` goes 001 after edge 6, 011 after edge 8, 111 after edge 10; `ready_o` is 1 after edge 11; `sack_o` stays 0.
- **Single soft request:** in RUN, pulse `sreq_i=01` until ack → `nreset_o=000` after S; 001 at S+4; 111 at S+8; `sack_o=01` for one cycle at S+9.
- **Simultaneous requests:** in RUN, `sreq_i=11` at the same edge → one sequence, a single `sack_o=11` pulse at S+9.
- **Request during sequence:** `sreq_i[1]` rises at S+3 during a req0 sequence → `sack_o=01` at S+9. `sreq_i[1]` is then resampled in the second RUN cycle, S+11, and `sack_o=10` fires at S+20.
- **Reset mid-sequence:** assert `reset_i` low at S+5 → `nreset_o=000` and `ready_o=0` with no clock edge needed; no `sack_o` is ever issued for req0. After release, the power-up schedule repeats.
- **Degenerate parameters:** `STAGES=1`, `HOLD_CYCLES=1` → `nreset_o[0]` goes high after edge 3 and `ready_o` after edge 4.
